// File: rtl/fsm_tree_gen.sv
// fsm_tree_gen: parametrised binary-tree control FSM with 2^STATE_W states.
// Each step moves state s to 2s+1 (condition true) or 2s+2 (false), mod N.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset, highest priority
//   en         step enable
//   input1     condition input A
//   input2     condition input B
//   load       synchronous state load (beats en)
//   load_state value written to state on load
//   state      current state (registered)
//   wrap       one-cycle pulse after a step moved state from nonzero to 0
//   stuck      sticky flag, set once dwell reaches STUCK_LIMIT
//   dwell      consecutive steps that left state unchanged (saturating)
//   step_cnt   steps performed since reset/load (saturating)
module fsm_tree_gen #(
    parameter int STATE_W     = 4,
    parameter int CNT_W       = 16,
    parameter int DWELL_W     = 8,
    parameter int STUCK_LIMIT = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               input1,
    input  logic               input2,
    input  logic               load,
    input  logic [STATE_W-1:0] load_state,
    output logic [STATE_W-1:0] state,
    output logic               wrap,
    output logic               stuck,
    output logic [DWELL_W-1:0] dwell,
    output logic [CNT_W-1:0]   step_cnt
);

    localparam logic [STATE_W+1:0] ONE       = (STATE_W+2)'(1);
    localparam logic [STATE_W+1:0] TWO       = (STATE_W+2)'(2);
    localparam logic [DWELL_W-1:0] DWELL_MAX = {DWELL_W{1'b1}};
    localparam logic [DWELL_W-1:0] LIMIT     = DWELL_W'(STUCK_LIMIT);
    localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};

    logic               cond;
    logic [STATE_W+1:0] wide_next;
    logic [STATE_W-1:0] next_state;
    logic [DWELL_W-1:0] dwell_step;
    logic [CNT_W-1:0]   cnt_step;
    logic               stuck_hit;

    // Condition selected by the low three state bits.
    always_comb begin
        cond = 1'b0;
        case (state[2:0])
            3'd0:    cond =  input1 &  input2;
            3'd1:    cond = !input1 &  input2;
            3'd2:    cond =  input1 & !input2;
            3'd3:    cond = !input1 & !input2;
            3'd4:    cond =  input1 |  input2;
            3'd5:    cond = !input1 |  input2;
            3'd6:    cond =  input1 | !input2;
            default: cond = !input1 | !input2;
        endcase
    end

    // Two guard bits keep 2s+2 exact before truncation to mod N.
    always_comb begin
        wide_next  = {1'b0, state, 1'b0} + (cond ? ONE : TWO);
        next_state = wide_next[STATE_W-1:0];
    end

    // Dwell only grows across self-loop steps; any real move clears it.
    always_comb begin
        dwell_step = '0;
        if (next_state == state) begin
            dwell_step = (dwell == DWELL_MAX) ? dwell
                                              : dwell + DWELL_W'(1);
        end
        stuck_hit = (dwell_step >= LIMIT);
        cnt_step  = (step_cnt == CNT_MAX) ? step_cnt
                                          : step_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= '0;
            wrap     <= 1'b0;
            stuck    <= 1'b0;
            dwell    <= '0;
            step_cnt <= '0;
        end else if (load) begin
            state    <= load_state;
            wrap     <= 1'b0;
            stuck    <= 1'b0;
            dwell    <= '0;
            step_cnt <= '0;
        end else if (en) begin
            state    <= next_state;
            wrap     <= (state != '0) && (next_state == '0);
            stuck    <= stuck | stuck_hit;
            dwell    <= dwell_step;
            step_cnt <= cnt_step;
        end else begin
            wrap     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fsm_tree_gen.sv
// Testbench for fsm_tree_gen: table-driven vectors, hand sequences and
// randomized stimulus against an arithmetic reference model.
module tb_fsm_tree_gen;

    logic       clk = 1'b0;
    logic       reset, en, input1, input2, load;
    logic [7:0] ls;

    logic [3:0]  st_a;
    logic        wrap_a, stuck_a;
    logic [7:0]  dwell_a;
    logic [15:0] cnt_a;

    logic [4:0] st_b;
    logic       wrap_b, stuck_b;
    logic [2:0] dwell_b;
    logic [2:0] cnt_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fsm_tree_gen dut_a (
        .clk(clk), .reset(reset), .en(en),
        .input1(input1), .input2(input2),
        .load(load), .load_state(ls[3:0]),
        .state(st_a), .wrap(wrap_a), .stuck(stuck_a),
        .dwell(dwell_a), .step_cnt(cnt_a)
    );

    fsm_tree_gen #(
        .STATE_W(5), .CNT_W(3), .DWELL_W(3), .STUCK_LIMIT(5)
    ) dut_b (
        .clk(clk), .reset(reset), .en(en),
        .input1(input1), .input2(input2),
        .load(load), .load_state(ls[4:0]),
        .state(st_b), .wrap(wrap_b), .stuck(stuck_b),
        .dwell(dwell_b), .step_cnt(cnt_b)
    );

    // Reference model, one slot per instance.
    int W[2]    = '{4, 5};
    int CMAX[2] = '{65535, 7};
    int DMAX[2] = '{255, 7};
    int LIM[2]  = '{8, 5};
    int m_st[2], m_w[2], m_sk[2], m_dw[2], m_ct[2];

    function automatic int tree_next(int s, bit a, bit b, int w);
        int  k;
        bit  x, y, c;
        k = s % 8;
        x = a ^ k[0];
        y = b ^ k[1];
        c = (k < 4) ? (x & y) : (x | y);
        return (2 * s + (c ? 1 : 2)) % (1 << w);
    endfunction

    function automatic int min2(int p, int q);
        return (p < q) ? p : q;
    endfunction

    task automatic model(bit r, bit l, bit e, bit a, bit b, int lsv);
        int n;
        for (int i = 0; i < 2; i++) begin
            if (r) begin
                m_st[i] = 0; m_w[i] = 0; m_sk[i] = 0;
                m_dw[i] = 0; m_ct[i] = 0;
            end else if (l) begin
                m_st[i] = lsv % (1 << W[i]);
                m_w[i] = 0; m_sk[i] = 0; m_dw[i] = 0; m_ct[i] = 0;
            end else if (e) begin
                n = tree_next(m_st[i], a, b, W[i]);
                m_w[i] = (m_st[i] != 0 && n == 0) ? 1 : 0;
                m_dw[i] = (n == m_st[i]) ? min2(m_dw[i] + 1, DMAX[i]) : 0;
                if (m_dw[i] >= LIM[i]) m_sk[i] = 1;
                m_ct[i] = min2(m_ct[i] + 1, CMAX[i]);
                m_st[i] = n;
            end else begin
                m_w[i] = 0;
            end
        end
    endtask

    task automatic chk(string name, int idx, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s[%0d] got %0d want %0d", name, idx, act, exp);
        end
    endtask

    task automatic chk_model(int idx);
        chk("a_state", idx, int'(st_a),    m_st[0]);
        chk("a_wrap",  idx, int'(wrap_a),  m_w[0]);
        chk("a_stuck", idx, int'(stuck_a), m_sk[0]);
        chk("a_dwell", idx, int'(dwell_a), m_dw[0]);
        chk("a_cnt",   idx, int'(cnt_a),   m_ct[0]);
        chk("b_state", idx, int'(st_b),    m_st[1]);
        chk("b_wrap",  idx, int'(wrap_b),  m_w[1]);
        chk("b_stuck", idx, int'(stuck_b), m_sk[1]);
        chk("b_dwell", idx, int'(dwell_b), m_dw[1]);
        chk("b_cnt",   idx, int'(cnt_b),   m_ct[1]);
    endtask

    // Drive one cycle, advance the model, sample #1 after the edge.
    task automatic cyc(bit r, bit l, bit e, bit a, bit b, int lsv);
        reset = r; load = l; en = e; input1 = a; input2 = b;
        ls = 8'(lsv);
        model(r, l, e, a, b, lsv);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit r, l, e, a, b;
        int ls;
        int st, w, sk, dw, ct;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(bit r, bit l, bit e, bit a, bit b, int lsv,
                                int st, int w, int sk, int dw, int ct);
        vec_t v;
        v.r = r; v.l = l; v.e = e; v.a = a; v.b = b; v.ls = lsv;
        v.st = st; v.w = w; v.sk = sk; v.dw = dw; v.ct = ct;
        tbl.push_back(v);
    endfunction

    initial begin
        reset = 1'b1; load = 1'b0; en = 1'b0;
        input1 = 1'b0; input2 = 1'b0; ls = '0;

        // Expected values for the STATE_W=4 instance.
        add(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
        add(0, 0, 1, 1, 1, 0,   1, 0, 0, 0, 1);
        add(0, 0, 1, 1, 1, 0,   4, 0, 0, 0, 2);
        add(0, 0, 1, 1, 1, 0,   9, 0, 0, 0, 3);
        add(0, 1, 1, 1, 1, 9,   9, 0, 0, 0, 0);
        add(0, 0, 1, 0, 1, 0,   3, 0, 0, 0, 1);
        add(0, 0, 1, 0, 0, 0,   7, 0, 0, 0, 2);
        add(0, 0, 1, 1, 1, 0,   0, 1, 0, 0, 3);
        add(0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 3);
        add(0, 1, 0, 0, 0, 14, 14, 0, 0, 0, 0);
        for (int i = 1; i <= 9; i++)
            add(0, 0, 1, 0, 1, 0, 14, 0, (i >= 8) ? 1 : 0, i, i);
        add(0, 1, 1, 0, 1, 0,   0, 0, 0, 0, 0);
        add(0, 0, 1, 1, 1, 0,   1, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++)
            add(0, 0, 0, i[0], !i[0], 0, 1, 0, 0, 0, 1);
        add(1, 1, 1, 1, 1, 5,   0, 0, 0, 0, 0);

        @(posedge clk);
        #1;
        foreach (tbl[i]) begin
            cyc(tbl[i].r, tbl[i].l, tbl[i].e, tbl[i].a, tbl[i].b, tbl[i].ls);
            chk("t_state", i, int'(st_a),    tbl[i].st);
            chk("t_wrap",  i, int'(wrap_a),  tbl[i].w);
            chk("t_stuck", i, int'(stuck_a), tbl[i].sk);
            chk("t_dwell", i, int'(dwell_a), tbl[i].dw);
            chk("t_cnt",   i, int'(cnt_a),   tbl[i].ct);
            chk_model(i);
        end

        // STATE_W=5: 31 steps to 0 with wrap, 30 steps to 29.
        cyc(0, 1, 0, 0, 0, 31);
        chk("b_ld31", 0, int'(st_b), 31);
        cyc(0, 0, 1, 1, 1, 0);
        chk("b_wrap_st", 0, int'(st_b), 0);
        chk("b_wrap", 0, int'(wrap_b), 1);
        cyc(0, 0, 0, 1, 1, 0);
        chk("b_wrap_drop", 0, int'(wrap_b), 0);
        cyc(0, 1, 0, 0, 0, 30);
        cyc(0, 0, 1, 0, 0, 0);
        chk("b_30_to_29", 0, int'(st_b), 29);
        chk_model(100);

        // CNT_W=3 saturation.
        cyc(0, 1, 0, 0, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            cyc(0, 0, 1, i[0], i[1], 0);
            chk("b_cnt_sat", i, int'(cnt_b), min2(i, 7));
        end

        // DWELL_W=3 saturation, STUCK_LIMIT=5 on self-loop state 30.
        cyc(0, 1, 0, 0, 0, 30);
        for (int i = 1; i <= 9; i++) begin
            cyc(0, 0, 1, 0, 1, 0);
            chk("b_loop_st", i, int'(st_b), 30);
            chk("b_dwell_sat", i, int'(dwell_b), min2(i, 7));
            chk("b_stuck", i, int'(stuck_b), (i >= 5) ? 1 : 0);
        end
        chk_model(200);

        // Randomized run against the model.
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(0, 79) == 0,
                $urandom_range(0, 9) == 0,
                $urandom_range(0, 9) < 8,
                1'($urandom), 1'($urandom),
                int'($urandom_range(0, 255)));
            chk_model(1000 + i);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fsm_tree_gen.md
Name: fsm_tree_gen

Overview:
- Parametrised successor to the fixed 16-state two-input tree FSM.
- Generalises the state space to 2^STATE_W states using a closed-form next-state rule.
- Adds step enable, synchronous state load, wrap detection, dwell tracking with a stuck flag, and a saturating transition counter.
- Sits in the control-FSM test-structure family. Used as a scalable stimulus/target FSM for equivalence and bug-injection work.

Parameters:
- STATE_W, 4: state register width; number of states N = 2^STATE_W; legal range 3..8.
- CNT_W, 16: width of the transition counter step_cnt.
- DWELL_W, 8: width of the dwell counter.
- STUCK_LIMIT, 8: dwell count at which stuck asserts; must be between 1 and 2^DWELL_W-1.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: synchronous, active-high; highest priority.
- en, input, 1: step enable; state advances only when 1.
- input1, input, 1: condition input A.
- input2, input, 1: condition input B.
- load, input, 1: synchronous state load request.
- load_state, input, STATE_W: value written to state on load.
- state, output, STATE_W: current state (registered).
- wrap, output, 1: one-cycle pulse; the last update moved state from nonzero to 0 via a step.
- stuck, output, 1: sticky flag; dwell reached STUCK_LIMIT.
- dwell, output, DWELL_W: consecutive steps that left state unchanged; saturating.
- step_cnt, output, CNT_W: count of performed steps since reset/load; saturating.

Behaviour:
- Reset (reset=1 at posedge): state=0, wrap=0, stuck=0, dwell=0, step_cnt=0. Overrides load and en.
- Priority per cycle: reset > load > en > hold.
- Load (load=1, reset=0):
  - state<=load_state; dwell<=0; step_cnt<=0; wrap<=0; stuck<=0.
  - en is ignored that cycle.
- Step (en=1, load=0, reset=0):
  - Let s=state, k=s[2:0], A=input1, B=input2.
  - cond by k: 0: A&B; 1: !A&B; 2: A&!B; 3: !A&!B; 4: A|B; 5: !A|B; 6: A|!B; 7: !A|!B.
  - next = (2s+1) mod N if cond, else (2s+2) mod N. Computed in STATE_W+2 bits, then truncated to the low STATE_W bits.
  - With STATE_W=4 this reproduces the 16-state table exactly, e.g. S9 with cond !A&B -> S3, else S4.
- Hold (en=0, load=0): state, dwell, step_cnt, stuck unchanged; wrap<=0.
- step_cnt: +1 on every step; saturates at 2^CNT_W-1.
- dwell:
  - On a step with next==s, dwell+1, saturating at 2^DWELL_W-1.
  - On a step with next!=s, dwell<=0.
  - Self-loop states are N-2 (not cond) and N-1 (cond).
- stuck: set on the cycle dwell's registered value becomes >= STUCK_LIMIT. Stays set until reset or load.
- wrap: registered; asserted exactly in the cycle after a step where s!=0 and next==0. A load to 0 does not assert wrap.
- Latency: all outputs update one clock after the qualifying edge; no combinational input-to-output paths.
- Every state is legal for any STATE_W; no default/illegal recovery needed.
- Reset mid-run: all counters and flags clear in the same edge, regardless of en/load.

Test Plan:
- STATE_W=4, reset, then en=1 with A=1,B=1 for 3 cycles -> state 0->1->4->9; step_cnt=3; dwell=0; wrap never asserted.
- STATE_W=4, load 9, en=1, A=0,B=1 -> state=3 (original intent). Then A=0,B=0 -> state=7. Then A=1,B=1 -> state=0, with wrap=1 for exactly one cycle.
- STATE_W=4, load 14, en=1, A=0,B=1 held for 9 steps -> state stays 14; dwell counts 1..9; stuck rises when dwell=8 and remains 1. Then load 0 -> stuck=0, dwell=0.
- STATE_W=5, load 31, A=1,B=1 -> state=0 (2*31+2 mod 32), wrap=1. Then load 30, A=0,B=0 -> (61 mod 32)=29 since k=6 gives A|!B=1.
- en=0 for 5 cycles with toggling inputs -> state, dwell, step_cnt frozen; wrap=0. Then reset=1 together with load=1, load_state=5 -> state=0, all counters 0.
- CNT_W=3, 10 consecutive steps -> step_cnt saturates at 7 and stays.
